// File: rtl/drum_sample_player.sv
// -----------------------------------------------------------------------------
// drum_sample_player
//
// Plays back a drum/cymbal sample stored in an on-chip single-port RAM. When
// triggered, the block reads one word per audio sample tick and scales it by
// an 8-bit unsigned gain (128 = unity) with saturation. Each result goes
// downstream over a valid/ready handshake.
//
// Memory timing: the RAM registers its address when chipselect and clken are
// high, and its q output is not registered. Data for the address presented in
// FETCH can therefore be read during the following CAPTURE cycle.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset (synchronous release upstream)
//   trigger        single-cycle start/restart pulse
//   gain[7:0]      unsigned gain, 128 = unity; sampled only on a trigger cycle
//   sample_tick    single-cycle audio-rate strobe
//   mem_address    word address to the sample memory (BASE_ADDR + ptr)
//   mem_chipselect memory select, high only in FETCH
//   mem_clken      memory clock enable, high only in FETCH
//   mem_readdata   memory read data, valid the cycle after FETCH
//   out_sample     scaled, saturated sample
//   out_valid      out_sample valid; held until out_ready
//   out_ready      downstream accepts the current beat
//   busy           playback active (not IDLE)
//   done           one-cycle pulse, registered, in the cycle after the last
//                  sample is accepted
//   overrun_cnt    saturating count of sample_ticks dropped while a beat was
//                  still in flight
// -----------------------------------------------------------------------------
module drum_sample_player #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int BASE_ADDR  = 0,
    parameter int SAMPLE_LEN = 48384
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trigger,
    input  logic [7:0]        gain,
    input  logic              sample_tick,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] out_sample,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [7:0]        overrun_cnt
);

    // Pointer width is just wide enough to reach SAMPLE_LEN-1.
    localparam int PTR_W = (SAMPLE_LEN > 1) ? $clog2(SAMPLE_LEN) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(SAMPLE_LEN - 1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

    // Product width: DATA_W signed data times a 9-bit non-negative gain.
    localparam int PW = DATA_W + 9;
    localparam logic signed [PW-1:0] SAT_MAX = {{10{1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{10{1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_FETCH,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [PTR_W-1:0]  r_ptr;
    logic [7:0]        r_gain;
    logic [7:0]        r_gain_pend;
    logic              r_restart_pend;
    logic [DATA_W-1:0] r_out_sample;
    logic              r_done;
    logic [7:0]        r_overrun;

    logic              w_accept;
    logic              w_last;
    logic              w_restart;
    logic              w_tick_drop;

    logic signed [PW-1:0] w_data_ext;
    logic signed [PW-1:0] w_gain_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_scaled;
    logic [DATA_W-1:0]    w_sat;

    // -------------------------------------------------------------------------
    // Control decodes
    // -------------------------------------------------------------------------
    assign w_accept = (r_state == S_OUT) && out_ready;
    assign w_last   = (r_ptr == LAST_PTR);

    // A restart starts playback at word 0. A trigger outside OUT aborts at
    // once. In OUT the current beat is never retracted, so the restart waits
    // for acceptance. The trigger can arrive on the acceptance cycle or it can
    // already be pending.
    assign w_restart = (trigger && (r_state != S_IDLE) && (r_state != S_OUT))
                     || (trigger && r_state == S_IDLE)
                     || (w_accept && (trigger || r_restart_pend));

    // Ticks are expected only in WAIT_TICK. A tick in IDLE is ignored silently.
    // A tick while a beat is in flight is counted as an overrun.
    assign w_tick_drop = sample_tick
                       && (r_state != S_IDLE)
                       && (r_state != S_WAIT_TICK);

    // -------------------------------------------------------------------------
    // Gain arithmetic: (data * {0,gain}) >>> 7, saturated to DATA_W
    // -------------------------------------------------------------------------
    assign w_data_ext = {{9{mem_readdata[DATA_W-1]}}, mem_readdata};
    assign w_gain_ext = {{(PW-8){1'b0}}, r_gain};
    assign w_prod     = w_data_ext * w_gain_ext;
    assign w_scaled   = w_prod >>> 7;

    always_comb begin
        if (w_scaled > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if (w_scaled < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end else begin
            w_sat = w_scaled[DATA_W-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: default assignment first so every path drives w_state_nxt and no
    // latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (trigger) w_state_nxt = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                // A trigger here only relatches gain and pointer. It
                // overrides a coincident tick.
                if (!trigger && sample_tick) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_state_nxt = trigger ? S_WAIT_TICK : S_CAPTURE;
            end
            S_CAPTURE: begin
                // Abort discards the word currently on mem_readdata.
                w_state_nxt = trigger ? S_WAIT_TICK : S_OUT;
            end
            S_OUT: begin
                if (w_accept) begin
                    if (trigger || r_restart_pend) begin
                        w_state_nxt = S_WAIT_TICK;
                    end else if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAIT_TICK;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs decoded from state
    // -------------------------------------------------------------------------
    always_comb begin
        mem_chipselect = 1'b0;
        mem_clken      = 1'b0;
        out_valid      = 1'b0;
        busy           = 1'b1;
        unique case (r_state)
            S_IDLE:      busy = 1'b0;
            S_FETCH: begin
                mem_chipselect = 1'b1;
                mem_clken      = 1'b1;
            end
            S_OUT:       out_valid = 1'b1;
            default: ;
        endcase
    end

    // The address follows ptr at all times. The RAM samples it only in FETCH.
    // ptr is 0 in reset, so the address idles at BASE_ADDR.
    assign mem_address = BASE_A + ADDR_W'(r_ptr);

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr          <= '0;
            r_gain         <= 8'd128;
            r_gain_pend    <= 8'd128;
            r_restart_pend <= 1'b0;
            r_out_sample   <= '0;
            r_done         <= 1'b0;
            r_overrun      <= 8'd0;
        end else begin
            // Pointer and active gain
            if (w_restart) begin
                r_ptr <= '0;
                // A trigger on this cycle supplies the gain directly.
                // Otherwise the restart was pending and uses the gain
                // stored at that trigger.
                r_gain <= trigger ? gain : r_gain_pend;
            end else if (w_accept && !w_last) begin
                r_ptr <= r_ptr + 1'b1;
            end

            // Deferred restart for a trigger seen while a beat waits in OUT
            if (w_accept) begin
                r_restart_pend <= 1'b0;
            end else if (trigger && r_state == S_OUT) begin
                r_restart_pend <= 1'b1;
                r_gain_pend    <= gain;
            end

            if (r_state == S_CAPTURE && !trigger) begin
                r_out_sample <= w_sat;
            end

            // A restart takes priority over completion.
            r_done <= w_accept && w_last && !trigger && !r_restart_pend;

            if (w_tick_drop && r_overrun != 8'hFF) begin
                r_overrun <= r_overrun + 8'd1;
            end
        end
    end

    assign out_sample  = r_out_sample;
    assign done        = r_done;
    assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_drum_sample_player.sv
// -----------------------------------------------------------------------------
// tb_drum_sample_player
//
// Directed bench for drum_sample_player with SAMPLE_LEN=4. A small RAM model
// holds {0x0100, 0xFF00, 0x7FFF, 0x8000}. It has a registered address and an
// unregistered q. Inputs are driven on the falling edge. Outputs are sampled on
// the falling edge, away from the rising edge the DUT uses.
//
// Expected scaled values, computed as (data * gain) >>> 7 and saturated:
//   gain 128: 0x0100 0xFF00 0x7FFF 0x8000
//   gain 255: 0x01FE 0xFE02 0x7FFF 0x8000
//   gain   0: 0x0000 for every word
// -----------------------------------------------------------------------------
module tb_drum_sample_player;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trigger;
    logic [7:0]  gain;
    logic        sample_tick;
    logic [15:0] mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic [15:0] mem_readdata;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [7:0]  overrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [15:0] mem [0:3];
    logic [1:0]  r_maddr = 2'd0;

    always #5 clk = ~clk;

    drum_sample_player #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .BASE_ADDR (0),
        .SAMPLE_LEN(4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .trigger       (trigger),
        .gain          (gain),
        .sample_tick   (sample_tick),
        .mem_address   (mem_address),
        .mem_chipselect(mem_chipselect),
        .mem_clken     (mem_clken),
        .mem_readdata  (mem_readdata),
        .out_sample    (out_sample),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .overrun_cnt   (overrun_cnt)
    );

    // RAM model: the address is registered on a selected, enabled edge and q
    // is read combinationally from that registered address.
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) r_maddr <= mem_address[1:0];
    end
    assign mem_readdata = mem[r_maddr];

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        trigger     = 1'b0;
        gain        = 8'd0;
        sample_tick = 1'b0;
        out_ready   = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One-cycle trigger. Gain is then scrambled, which checks that the DUT
    // sampled it on the trigger cycle only.
    task automatic pulse_trigger(input logic [7:0] g);
        @(negedge clk);
        trigger = 1'b1;
        gain    = g;
        @(negedge clk);
        trigger = 1'b0;
        gain    = 8'hAA;
    endtask

    // Tick in WAIT_TICK, then check the FETCH address, the idle CAPTURE cycle
    // and the beat at T+3. With accept=1, out_ready is high and the beat is
    // taken on the following edge, so done/busy are checked after it.
    task automatic do_beat(input logic [15:0] exp_data,
                           input logic [15:0] exp_addr,
                           input logic exp_last, input logic accept);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("fetch_cs",    mem_chipselect, 1);
        check("fetch_clken", mem_clken, 1);
        check("fetch_addr",  mem_address, exp_addr);
        @(negedge clk);
        check("capture_valid", out_valid, 0);
        check("capture_cs",    mem_chipselect, 0);
        @(negedge clk);
        check("out_valid",  out_valid, 1);
        check("out_sample", out_sample, exp_data);
        if (accept) begin
            @(negedge clk);
            check("post_valid", out_valid, 0);
            check("post_done",  done, exp_last);
            check("post_busy",  busy, !exp_last);
        end
    endtask

    initial begin
        int d0;
        logic ok;

        mem[0] = 16'h0100;
        mem[1] = 16'hFF00;
        mem[2] = 16'h7FFF;
        mem[3] = 16'h8000;

        // ---- Reset state ----
        do_reset();
        check("rst_out_sample", out_sample, 0);
        check("rst_out_valid",  out_valid, 0);
        check("rst_busy",       busy, 0);
        check("rst_done",       done, 0);
        check("rst_overrun",    overrun_cnt, 0);
        check("rst_cs",         mem_chipselect, 0);
        check("rst_clken",      mem_clken, 0);
        check("rst_addr",       mem_address, 0);

        // ---- Unity gain playback, ticks about 20 cycles apart ----
        d0 = done_cnt;
        pulse_trigger(8'd128);
        check("trig_busy", busy, 1);
        do_beat(16'h0100, 16'd0, 1'b0, 1'b1);
        repeat (14) @(negedge clk);
        do_beat(16'hFF00, 16'd1, 1'b0, 1'b1);
        repeat (14) @(negedge clk);
        do_beat(16'h7FFF, 16'd2, 1'b0, 1'b1);
        repeat (14) @(negedge clk);
        do_beat(16'h8000, 16'd3, 1'b1, 1'b1);
        @(negedge clk);
        check("done_once",    done_cnt - d0, 1);
        check("done_dropped", done, 0);
        check("idle_busy",    busy, 0);

        // ---- Gain 255: saturation both ways ----
        do_reset();
        pulse_trigger(8'd255);
        do_beat(16'h01FE, 16'd0, 1'b0, 1'b1);
        do_beat(16'hFE02, 16'd1, 1'b0, 1'b1);
        do_beat(16'h7FFF, 16'd2, 1'b0, 1'b1);
        do_beat(16'h8000, 16'd3, 1'b1, 1'b1);

        // Trigger and tick together in IDLE: trigger wins, tick is ignored
        @(negedge clk);
        trigger     = 1'b1;
        sample_tick = 1'b1;
        gain        = 8'd0;
        @(negedge clk);
        trigger     = 1'b0;
        sample_tick = 1'b0;
        gain        = 8'hAA;
        check("idle_tick_busy",  busy, 1);
        check("idle_tick_nofetch", mem_chipselect, 0);
        check("idle_tick_overrun", overrun_cnt, 0);
        // Gain 0 yields 0
        do_beat(16'h0000, 16'd0, 1'b0, 1'b1);

        // ---- Backpressure: 50 cycles in OUT with two ticks ----
        do_reset();
        pulse_trigger(8'd128);
        out_ready = 1'b0;
        do_beat(16'h0100, 16'd0, 1'b0, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            sample_tick = (i == 10 || i == 30);
            @(negedge clk);
            if (out_valid !== 1'b1 || out_sample !== 16'h0100) ok = 1'b0;
        end
        sample_tick = 1'b0;
        check("stall_stable",  ok, 1);
        check("stall_overrun", overrun_cnt, 2);
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_accepted", out_valid, 0);
        check("stall_busy",     busy, 1);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_chipselect !== 1'b0 || out_valid !== 1'b0) ok = 1'b0;
        end
        check("stall_wait_fresh_tick", ok, 1);
        do_beat(16'hFF00, 16'd1, 1'b0, 1'b1);

        // ---- Trigger during FETCH of word 2 ----
        do_reset();
        pulse_trigger(8'd128);
        do_beat(16'h0100, 16'd0, 1'b0, 1'b1);
        do_beat(16'hFF00, 16'd1, 1'b0, 1'b1);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("abort_fetch_addr", mem_address, 2);
        trigger = 1'b1;
        gain    = 8'd255;
        @(negedge clk);
        trigger = 1'b0;
        gain    = 8'hAA;
        check("abort_busy", busy, 1);
        check("abort_cs",   mem_chipselect, 0);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        check("abort_no_beat", ok, 1);
        do_beat(16'h01FE, 16'd0, 1'b0, 1'b1);

        // ---- Trigger in OUT on the last word with out_ready low ----
        do_reset();
        d0 = done_cnt;
        pulse_trigger(8'd128);
        do_beat(16'h0100, 16'd0, 1'b0, 1'b1);
        do_beat(16'hFF00, 16'd1, 1'b0, 1'b1);
        do_beat(16'h7FFF, 16'd2, 1'b0, 1'b1);
        out_ready = 1'b0;
        do_beat(16'h8000, 16'd3, 1'b0, 1'b0);
        @(negedge clk);
        trigger = 1'b1;
        gain    = 8'd0;
        @(negedge clk);
        trigger = 1'b0;
        gain    = 8'hAA;
        check("pend_valid",  out_valid, 1);
        check("pend_sample", out_sample, 16'h8000);
        out_ready = 1'b1;
        @(negedge clk);
        check("pend_done",  done, 0);
        check("pend_busy",  busy, 1);
        check("pend_valid_drop", out_valid, 0);
        do_beat(16'h0000, 16'd0, 1'b0, 1'b1);
        do_beat(16'h0000, 16'd1, 1'b0, 1'b1);
        do_beat(16'h0000, 16'd2, 1'b0, 1'b1);

        // Trigger on the same cycle as acceptance of the last word
        out_ready = 1'b0;
        do_beat(16'h0000, 16'd3, 1'b0, 1'b0);
        @(negedge clk);
        trigger   = 1'b1;
        gain      = 8'd128;
        out_ready = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        gain    = 8'hAA;
        check("coinc_done", done, 0);
        check("coinc_busy", busy, 1);
        do_beat(16'h0100, 16'd0, 1'b0, 1'b1);
        check("restart_no_done", done_cnt - d0, 0);

        // ---- Asynchronous reset mid-CAPTURE ----
        do_reset();
        pulse_trigger(8'd128);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("areset_fetch_cs", mem_chipselect, 1);
        @(negedge clk);
        check("areset_in_capture", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("areset_busy",  busy, 0);
        check("areset_valid", out_valid, 0);
        check("areset_cs",    mem_chipselect, 0);
        check("areset_addr",  mem_address, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            sample_tick = (i % 5 == 0);
            @(negedge clk);
            if (out_valid !== 1'b0 || mem_chipselect !== 1'b0 || busy !== 1'b0)
                ok = 1'b0;
        end
        sample_tick = 1'b0;
        check("areset_quiet",   ok, 1);
        check("areset_overrun", overrun_cnt, 0);
        check("areset_sample",  out_sample, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
